// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Multi-port register file with per-register pending-write counters.
//            Optional write-to-read bypass enabled by macro REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int PC_IDX  = 15,
  parameter int MAXPEND = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*WIDTH-1:0]    rd,
  output logic [NRD-1:0]          rbusy,
  input  logic [WIDTH-1:0]        pc_in,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [WIDTH-1:0]        wd,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic                    rsv_full,
  output logic                    err
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(MAXPEND + 1);
  localparam logic [CNT_W-1:0]  c_max = CNT_W'(MAXPEND);
  localparam logic [ADDR_W-1:0] c_pc  = ADDR_W'(PC_IDX);

  logic [WIDTH-1:0] r_rf  [NREGS];
  logic [CNT_W-1:0] r_cnt [NREGS];
  logic             r_err;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic             w_we_ok;

  assign w_we_ok  = we && (wa != c_pc);
  // Conservative: a same-cycle writeback does not free a slot.
  assign rsv_full = (r_cnt[rsv_addr] == c_max);
  assign err      = r_err;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (ADDR_W'(r) != c_pc) begin
        w_inc[r] = rsv_en && (rsv_addr == ADDR_W'(r)) && !rsv_full;
        w_dec[r] = we && (wa == ADDR_W'(r)) && (r_cnt[r] != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_rf[r]  <= '0;
        r_cnt[r] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (w_we_ok) begin
        r_rf[wa] <= wd;
        if (r_cnt[wa] == '0) r_err <= 1'b1;
      end
      for (int r = 0; r < NREGS; r++) begin
        if (w_inc[r] && !w_dec[r])
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        else if (w_dec[r] && !w_inc[r])
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [WIDTH-1:0]  w_rd;
    logic              w_busy;

    assign w_ra = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd   = r_rf[w_ra];
      w_busy = (r_cnt[w_ra] != '0);
      if (w_ra == c_pc) begin
        w_rd   = pc_in;
        w_busy = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      // Writeback in flight is forwarded; if it is the last pending one, not busy.
      else if (w_we_ok && (wa == w_ra)) begin
        w_rd = wd;
        if (r_cnt[w_ra] == CNT_W'(1)) w_busy = 1'b0;
      end
`endif
    end

    assign rd[i*WIDTH +: WIDTH] = w_rd;
    assign rbusy[i]             = w_busy;
  end

endmodule

`default_nettype wire
